fifo_stream_reader: RTL



---
 rtl/fifo_stream_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Purpose : pops a sync FIFO (rd_en from empty flag), absorbs its read latency and
//           presents the words as a valid/ready stream with an end-of-line marker.
// Latency : first m_valid appears RD_LATENCY+1 cycles after the first fifo_rd_en.
// Backpressure: reads are issued only while buffered + in-flight words < BUF_DEPTH,
//           so m_ready may stall for any number of cycles without overflow.
// Ports   : clk/rst (sync, active-high); enable gates new reads; fifo_empty/
//           fifo_rd_data/fifo_rd_en face the FIFO; m_data/m_valid/m_last/m_ready
//           are the output stream; line_done pulses one cycle after the m_last
//           word is accepted.
module fifo_stream_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int BUF_DEPTH  = 4,
   parameter int LINE_LEN   = 1920,
   parameter int LEN_WIDTH  = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_rd_en,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   output logic                  m_last,
   input  logic                  m_ready,
   output logic                  line_done
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int OCC_W = $clog2(BUF_DEPTH + 1);
   localparam int SUM_W = OCC_W + 1;

   logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic                  line_done_q, line_done_d;

   logic                  land;       // a FIFO word is on fifo_rd_data this cycle
   logic [OCC_W-1:0]      in_flight;  // reads issued but not yet landed
   logic                  xfer;
   logic                  at_last;

   // Reads are throttled against buffered + in-flight so every issued read has a
   // guaranteed slot. rst gates the read so nothing is popped in the reset cycle.
   assign fifo_rd_en = !rst && enable && !fifo_empty &&
                       (({1'b0, occ_q} + {1'b0, in_flight}) < SUM_W'(BUF_DEPTH));

   if (RD_LATENCY == 0) begin : g_lat0
      // Show-ahead FIFO: the data is already present when rd_en is high.
      assign land      = fifo_rd_en;
      assign in_flight = '0;
   end else begin : g_latn
      logic [RD_LATENCY-1:0] pipe_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            pipe_q <= '0;
         end else begin
            pipe_q[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LATENCY; i++) begin
               pipe_q[i] <= pipe_q[i-1];
            end
         end
      end

      always_comb begin
         in_flight = '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + OCC_W'(pipe_q[i]);
         end
      end

      // Clearing the pipe on reset is what discards words still in flight.
      assign land = pipe_q[RD_LATENCY-1];
   end

   assign m_valid   = (occ_q != '0);
   assign xfer      = m_valid && m_ready;
   assign at_last   = (cnt_q == LEN_WIDTH'(LINE_LEN - 1));
   // Head entry masked so the data bus reads zero while the buffer is empty.
   assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
   assign m_last    = m_valid && at_last;
   assign line_done = line_done_q;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      occ_d       = occ_q;
      cnt_d       = cnt_q;
      line_done_d = 1'b0;

      if (land) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (xfer) begin
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
         cnt_d       = at_last ? '0 : cnt_q + LEN_WIDTH'(1);
         line_done_d = at_last;
      end

      // Land and transfer in the same cycle cancel out.
      case ({land, xfer})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         occ_q       <= '0;
         cnt_q       <= '0;
         line_done_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         occ_q       <= occ_d;
         cnt_q       <= cnt_d;
         line_done_q <= line_done_d;
      end
   end

   // Storage needs no reset: occupancy and pointers decide what is visible.
   always_ff @(posedge clk) begin
      if (land) begin
         mem_q[wr_ptr_q] <= fifo_rd_data;
      end
   end

endmodule
